flit_output_arbiter: RTL



---
 rtl/flit_output_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/flit_output_arbiter.sv
// Packet-locked round-robin arbiter sharing one router output link among NUM_REQ requesters.
// Optional stall watchdog compiled in with `define FLIT_ARB_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module flit_output_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int FLIT_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
    input  logic [NUM_REQ-1:0]            req_is_tail,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [FLIT_WIDTH-1:0]         out_flit,
    output logic                          out_is_tail,
    input  logic                          out_ready,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t         r_state;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_rr_ptr;

    logic           w_any;
    logic [IDW-1:0] w_sel;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_next_ptr;
    logic           w_xfer;
    logic           w_release;
    logic           w_timeout;

    // Scan offsets from highest to lowest so the last hit is the one closest to rr_ptr.
    // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
    always_comb begin
        w_any = 1'b0;
        w_sel = r_rr_ptr;
        w_sum = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(off);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end
            if (req_valid[w_sum[IDW-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        out_valid   = 1'b0;
        out_flit    = '0;
        out_is_tail = 1'b0;
        req_ready   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((r_state == ST_LOCKED) && (r_grant_id == IDW'(i))) begin
                out_valid    = req_valid[i];
                out_flit     = req_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                out_is_tail  = req_is_tail[i];
                req_ready[i] = out_ready;
            end
        end
    end

    assign w_xfer     = out_valid && out_ready;
    assign w_release  = (w_xfer && out_is_tail) || w_timeout;
    assign w_next_ptr = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    assign grant_id   = r_grant_id;
    assign busy       = (r_state == ST_LOCKED);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_sel;
                        r_state    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_release) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FLIT_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_stall_cnt;
    logic          r_timeout_err;

    // A transfer in the final stall cycle wins over the watchdog.
    assign w_timeout   = (r_state == ST_LOCKED) && !w_xfer &&
                         (r_stall_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if ((r_state != ST_LOCKED) || w_xfer || w_timeout) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
